costas_gain_sched: RTL and testbench

COSTAS_GAIN_SCHED -- requirements
Module: costas_gain_sched

---
 rtl/costas_gain_sched.sv | 180 ++++++++++++++++++
 tb/tb_costas_gain_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/costas_gain_sched.sv
// rtl/costas_gain_sched.sv - Costas loop lock detector and loop-gain scheduler
//
// Purpose: watches the Costas phase-error stream in fixed windows of counted
// samples, judges each window good or bad, and steps the NCO feedback shift
// from a wide acquisition value to a narrow tracking value as lock is gained.
//
// Ports:
//   clk            - single clock
//   rst_n          - asynchronous active-low reset, release synchronized to clk
//   en             - loop enable; low forces IDLE
//   err_tdata      - signed phase-error sample
//   err_tvalid     - error sample valid
//   feedback_shift - right-shift drive for the NCO phase block (registered)
//   locked         - lock indicator (registered)
//   state          - FSM state: IDLE=0 ACQUIRE=1 TRACK=2 LOCKED=3 (registered)

module costas_gain_sched #(
  parameter int WIDTH        = 16,
  parameter int ERR_THRESH   = 1024,
  parameter int WIN_LEN      = 256,
  parameter int BAD_MAX      = 8,
  parameter int LOCK_WINS    = 4,
  parameter int UNLOCK_WINS  = 2,
  parameter int SHIFT_WIDE   = 2,
  parameter int SHIFT_NARROW = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] err_tdata,
  input  logic                    err_tvalid,
  output logic [3:0]              feedback_shift,
  output logic                    locked,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  localparam logic [WIDTH:0]   THRESH    = (WIDTH+1)'(ERR_THRESH);
  localparam logic [15:0]      WIN_LAST  = 16'(WIN_LEN - 1);
  localparam logic [15:0]      BAD_LIM   = 16'(BAD_MAX);
  localparam logic [15:0]      LOCK_LIM  = 16'(LOCK_WINS);
  localparam logic [15:0]      UNLK_LIM  = 16'(UNLOCK_WINS);
  localparam logic [3:0]       SH_WIDE   = 4'(SHIFT_WIDE);
  localparam logic [3:0]       SH_NARROW = 4'(SHIFT_NARROW);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS  = {1'b0, {(WIDTH-1){1'b1}}};

  // Reset release synchronizer: assertion is immediate, release takes two edges.
  logic [1:0] rst_sync_q;
  logic       run_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run_ok = rst_sync_q[1];

  state_t      state_q;
  logic [3:0]  shift_q;
  logic        locked_q;
  logic [15:0] win_cnt_q;
  logic [15:0] bad_cnt_q;
  logic [15:0] good_run_q;
  logic [15:0] bad_run_q;

  logic [WIDTH-1:0] mag;
  logic             smp_bad;
  logic [15:0]      bad_cnt_d;
  logic             smp_cnt;
  logic             win_end;
  logic             win_good;

  always_comb begin
    mag = err_tdata;
    // The most negative code has no positive twin; clamp it to full scale.
    if (err_tdata == MOST_NEG) begin
      mag = MOST_POS;
    end else if (err_tdata[WIDTH-1]) begin
      mag = WIDTH'(-err_tdata);
    end
    smp_bad = ({1'b0, mag} > THRESH);

    // Saturating bad count including the current sample.
    bad_cnt_d = bad_cnt_q;
    if (smp_bad && (bad_cnt_q != 16'hFFFF)) begin
      bad_cnt_d = bad_cnt_q + 16'd1;
    end

    smp_cnt  = err_tvalid && (state_q != ST_IDLE);
    win_end  = smp_cnt && (win_cnt_q == WIN_LAST);
    win_good = (bad_cnt_d <= BAD_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= SH_WIDE;
      locked_q   <= 1'b0;
      win_cnt_q  <= '0;
      bad_cnt_q  <= '0;
      good_run_q <= '0;
      bad_run_q  <= '0;
    end else if (!run_ok || !en) begin
      // Held in IDLE until reset release completes; en low beats a window end.
      state_q    <= ST_IDLE;
      shift_q    <= SH_WIDE;
      locked_q   <= 1'b0;
      win_cnt_q  <= '0;
      bad_cnt_q  <= '0;
      good_run_q <= '0;
      bad_run_q  <= '0;
    end else if (state_q == ST_IDLE) begin
      state_q <= ST_ACQUIRE;
    end else if (smp_cnt && !win_end) begin
      win_cnt_q <= win_cnt_q + 16'd1;
      bad_cnt_q <= bad_cnt_d;
    end else if (win_end) begin
      win_cnt_q <= '0;
      bad_cnt_q <= '0;
      case (state_q)
        ST_ACQUIRE: begin
          if (!win_good) begin
            good_run_q <= '0;
          end else if (good_run_q + 16'd1 >= LOCK_LIM) begin
            state_q    <= ST_TRACK;
            shift_q    <= SH_WIDE + 4'd1;
            good_run_q <= '0;
          end else begin
            good_run_q <= good_run_q + 16'd1;
          end
        end
        ST_TRACK: begin
          if (!win_good) begin
            state_q <= ST_ACQUIRE;
            shift_q <= SH_WIDE;
          end else if (shift_q + 4'd1 >= SH_NARROW) begin
            // Clamped so the shift can never pass the narrow value.
            state_q  <= ST_LOCKED;
            shift_q  <= SH_NARROW;
            locked_q <= 1'b1;
          end else begin
            shift_q <= shift_q + 4'd1;
          end
          good_run_q <= '0;
          bad_run_q  <= '0;
        end
        ST_LOCKED: begin
          if (win_good) begin
            bad_run_q <= '0;
          end else if (bad_run_q + 16'd1 >= UNLK_LIM) begin
            state_q   <= ST_ACQUIRE;
            shift_q   <= SH_WIDE;
            locked_q  <= 1'b0;
            bad_run_q <= '0;
          end else begin
            bad_run_q <= bad_run_q + 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign state          = state_q;
  assign feedback_shift = shift_q;
  assign locked         = locked_q;

endmodule

// File: tb/tb_costas_gain_sched.sv
// tb/tb_costas_gain_sched.sv - directed self-checking bench for costas_gain_sched

module tb_costas_gain_sched;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic signed [15:0] err_tdata;
  logic               err_tvalid;
  logic [3:0]         feedback_shift;
  logic               locked;
  logic [1:0]         state;

  int checks;
  int failures;

  costas_gain_sched #(
    .WIDTH(16), .ERR_THRESH(100), .WIN_LEN(8), .BAD_MAX(1),
    .LOCK_WINS(2), .UNLOCK_WINS(2), .SHIFT_WIDE(2), .SHIFT_NARROW(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .err_tdata(err_tdata), .err_tvalid(err_tvalid),
    .feedback_shift(feedback_shift), .locked(locked), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int st, input int sh, input int lk);
    chk_eq({tag, ".state"}, int'(state), st);
    chk_eq({tag, ".shift"}, int'(feedback_shift), sh);
    chk_eq({tag, ".locked"}, int'(locked), lk);
  endtask

  task automatic smp(input logic signed [15:0] v);
    @(negedge clk);
    err_tdata  = v;
    err_tvalid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input int n, input logic signed [15:0] v);
    @(negedge clk);
    err_tdata  = v;
    err_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One window of 8 counted samples; the first nbad use bv, the rest gv.
  task automatic win(input int nbad, input logic signed [15:0] bv, input logic signed [15:0] gv);
    for (int i = 0; i < 8; i++) smp((i < nbad) ? bv : gv);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    en         = 1'b0;
    err_tdata  = '0;
    err_tvalid = 1'b0;

    #23;
    chk_out("reset", 0, 2, 0);

    // Release with en already high: no exit from IDLE before the third edge.
    en    = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_eq("rel_edge1", int'(state), 0);
    @(posedge clk); #1;
    chk_eq("rel_edge2", int'(state), 0);
    @(posedge clk); #1;
    chk_out("rel_edge3", 1, 2, 0);

    // Acquisition to lock on a clean error stream.
    win(0, 16'sd0, 16'sd50);
    chk_out("acq_w1", 1, 2, 0);
    for (int i = 0; i < 7; i++) smp(16'sd50);
    chk_out("acq_s15", 1, 2, 0);
    smp(16'sd50);
    chk_out("acq_s16", 2, 3, 0);
    win(0, 16'sd0, 16'sd50);
    chk_out("acq_s24", 2, 4, 0);
    win(0, 16'sd0, 16'sd50);
    chk_out("acq_s32", 3, 5, 1);

    // Loss of lock: bad, good, bad, bad.
    win(2, 16'sd101, 16'sd50);
    chk_out("lol_w1", 3, 5, 1);
    win(0, 16'sd0, 16'sd50);
    chk_out("lol_w2", 3, 5, 1);
    win(2, 16'sd101, 16'sd50);
    chk_out("lol_w3", 3, 5, 1);
    for (int i = 0; i < 7; i++) smp(16'sd101);
    chk_out("lol_s31", 3, 5, 1);
    smp(16'sd50);
    chk_out("lol_w4", 1, 2, 0);

    // Threshold boundary: 101 is bad, 100 is good, 2 bad clears the run.
    win(1, 16'sd101, 16'sd100);
    chk_out("thr_1bad_a", 1, 2, 0);
    win(2, -16'sd101, 16'sd100);
    chk_out("thr_2bad", 1, 2, 0);
    win(1, 16'sd101, 16'sd100);
    chk_out("thr_1bad_b", 1, 2, 0);
    win(1, 16'sd101, 16'sd100);
    chk_out("thr_1bad_c", 2, 3, 0);

    // Bad window in TRACK with shift 4.
    win(0, 16'sd0, 16'sd50);
    chk_out("trk_good", 2, 4, 0);
    for (int i = 0; i < 7; i++) smp(16'sd101);
    chk_out("trk_s7", 2, 4, 0);
    smp(16'sd101);
    chk_out("trk_bad", 1, 2, 0);

    // Most-negative input counts bad and clears the good run.
    win(0, 16'sd0, 16'sd50);
    chk_out("neg_pre", 1, 2, 0);
    win(8, -16'sd32768, 16'sd0);
    chk_out("neg_win", 1, 2, 0);
    win(0, 16'sd0, 16'sd50);
    chk_out("neg_post", 1, 2, 0);
    win(0, 16'sd0, 16'sd50);
    chk_out("neg_track", 2, 3, 0);

    // en low on a window-end sample in TRACK wins over the window result.
    for (int i = 0; i < 7; i++) smp(16'sd50);
    @(negedge clk);
    en         = 1'b0;
    err_tdata  = 16'sd50;
    err_tvalid = 1'b1;
    @(posedge clk); #1;
    chk_out("en_prio", 0, 2, 0);

    // Re-enable; invalid cycles in a window must not count.
    @(negedge clk);
    en         = 1'b1;
    err_tvalid = 1'b0;
    @(posedge clk); #1;
    chk_out("reen", 1, 2, 0);
    for (int i = 0; i < 4; i++) smp(16'sd50);
    idle_cyc(3, -16'sd32768);
    for (int i = 0; i < 4; i++) smp(16'sd50);
    chk_out("vld_w1", 1, 2, 0);
    for (int i = 0; i < 7; i++) smp(16'sd50);
    chk_out("vld_s7", 1, 2, 0);
    smp(16'sd50);
    chk_out("vld_w2", 2, 3, 0);
    win(0, 16'sd0, 16'sd50);
    win(0, 16'sd0, 16'sd50);
    chk_out("relock", 3, 5, 1);

    // Asynchronous reset mid-window in LOCKED.
    for (int i = 0; i < 3; i++) smp(16'sd50);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_eq("rst2_edge2", int'(state), 0);
    @(posedge clk); #1;
    chk_eq("rst2_edge3", int'(state), 1);
    for (int i = 0; i < 13; i++) smp(16'sd50);
    chk_out("rst2_s13", 1, 2, 0);
    for (int i = 0; i < 3; i++) smp(16'sd50);
    chk_out("rst2_s16", 2, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
